// File: rtl/vend_pkg.sv
// Shared types and coin decoding for the vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        REFUND   = 2'd2
    } vend_state_t;

    typedef logic [1:0] coin_code_t;

    localparam coin_code_t COIN_NONE = 2'b00;
    localparam coin_code_t COIN_1    = 2'b01;
    localparam coin_code_t COIN_3    = 2'b10;
    localparam coin_code_t COIN_5    = 2'b11;

    // Unit value of a coin code; zero marks a code the acceptor could not identify.
    function automatic logic [2:0] coin_units(input coin_code_t code);
        case (code)
            COIN_1:  return 3'd1;
            COIN_3:  return 3'd3;
            COIN_5:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_edge_detect.sv
// Turns the coin-present level into a single-cycle insertion strobe with its coin code.
module coin_edge_detect
    import vend_pkg::*;
(
    input  logic       clock,
    input  logic       reset_N,
    input  logic       coinInserted,
    input  coin_code_t coinValue,
    output logic       coinEdge,
    output coin_code_t coinCode
);

    logic coinInserted_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            coinInserted_q <= 1'b0;
        end else begin
            coinInserted_q <= coinInserted;
        end
    end

    assign coinEdge = coinInserted & ~coinInserted_q;
    assign coinCode = coinEdge ? coinValue : COIN_NONE;

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin credit accumulation, dispense/refund handshakes and idle auto-refund.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 4,
    parameter int TIMEOUT  = 255
)(
    input  logic                clock,
    input  logic                reset_N,
    input  logic                coinInserted,
    input  logic [1:0]          coinValue,
    input  logic                cancel,
    input  logic                dispAck,
    input  logic                changeAck,
    output logic                dispReq,
    output logic                changeReq,
    output logic [CREDIT_W-1:0] credit,
    output logic                coinReject,
    output logic                busy
);

    localparam int                CNT_W   = $clog2(TIMEOUT);
    localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);

    vend_state_t         state, stateNext;
    logic [CREDIT_W-1:0] creditNext;
    logic                rejectNext;
    logic [CNT_W-1:0]    idleCount, idleCountNext;

    logic                coinEdge;
    coin_code_t          coinCode;
    logic [2:0]          coinUnits;
    logic [CREDIT_W:0]   coinSum;
    logic                coinOk, creditZero, priceMet, timeoutHit;

    coin_edge_detect u_edge (
        .clock        (clock),
        .reset_N      (reset_N),
        .coinInserted (coinInserted),
        .coinValue    (coinValue),
        .coinEdge     (coinEdge),
        .coinCode     (coinCode)
    );

    // One extra bit on the sum exposes overflow instead of letting credit wrap.
    assign coinUnits  = coin_units(coinCode);
    assign coinSum    = {1'b0, credit} + (CREDIT_W+1)'(coinUnits);
    assign coinOk     = coinEdge && (coinUnits != 3'd0) && !coinSum[CREDIT_W];
    assign creditZero = (credit == '0);
    assign priceMet   = ({1'b0, credit} >= PRICE_X);
    assign timeoutHit = !creditZero && (idleCount == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (cancel && !creditZero) begin
                    stateNext = REFUND;
                end else if (coinEdge) begin
                    stateNext = IDLE;
                end else if (priceMet) begin
                    stateNext = DISPENSE;
                end else if (timeoutHit) begin
                    stateNext = REFUND;
                end
            end
            DISPENSE: if (dispAck) stateNext = IDLE;
            REFUND:   if (creditNext == '0) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_comb begin
        dispReq   = (state == DISPENSE);
        changeReq = (state == REFUND) && !creditZero;
        busy      = (state != IDLE);
    end

    // Credit is owned by whichever state is active; coins only land while IDLE.
    always_comb begin
        creditNext = credit;
        rejectNext = 1'b0;
        unique case (state)
            IDLE: begin
                if (cancel && !creditZero) begin
                    rejectNext = coinEdge;
                end else if (coinOk) begin
                    creditNext = coinSum[CREDIT_W-1:0];
                end else begin
                    rejectNext = coinEdge;
                end
            end
            DISPENSE: begin
                rejectNext = coinEdge;
                if (dispAck) creditNext = credit - PRICE_X[CREDIT_W-1:0];
            end
            REFUND: begin
                rejectNext = coinEdge;
                if (changeAck && !creditZero) creditNext = credit - CREDIT_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        idleCountNext = '0;
        if (state == IDLE && stateNext == IDLE && !creditZero && !coinEdge) begin
            idleCountNext = idleCount + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            credit     <= '0;
            coinReject <= 1'b0;
            idleCount  <= '0;
        end else begin
            credit     <= creditNext;
            coinReject <= rejectNext;
            idleCount  <= idleCountNext;
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Table-driven bench with a one-cycle scoreboard; a second instance with an unreachable price covers overflow.
module tb_vend_controller;
    import vend_pkg::*;

    logic       clock = 1'b0;
    logic       reset_N = 1'b0;
    logic       coinInserted = 1'b0;
    logic [1:0] coinValue = 2'b00;
    logic       cancel = 1'b0, dispAck = 1'b0, changeAck = 1'b0;

    logic       dispReq, changeReq, coinReject, busy;
    logic [3:0] credit;
    logic       b_dispReq, b_changeReq, b_coinReject, b_busy;
    logic [3:0] b_credit;

    vend_controller #(.PRICE(4), .CREDIT_W(4), .TIMEOUT(8)) dut (
        .clock(clock), .reset_N(reset_N), .coinInserted(coinInserted), .coinValue(coinValue),
        .cancel(cancel), .dispAck(dispAck), .changeAck(changeAck),
        .dispReq(dispReq), .changeReq(changeReq), .credit(credit),
        .coinReject(coinReject), .busy(busy)
    );

    vend_controller #(.PRICE(16), .CREDIT_W(4), .TIMEOUT(64)) dut_big (
        .clock(clock), .reset_N(reset_N), .coinInserted(coinInserted), .coinValue(coinValue),
        .cancel(cancel), .dispAck(dispAck), .changeAck(changeAck),
        .dispReq(b_dispReq), .changeReq(b_changeReq), .credit(b_credit),
        .coinReject(b_coinReject), .busy(b_busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] credit;
        logic       dispReq;
        logic       changeReq;
        logic       coinReject;
        logic       busy;
    } obs_t;

    typedef struct {
        logic       ins;
        logic [1:0] val;
        logic       can;
        logic       da;
        logic       ca;
        obs_t       exp;
    } vec_t;

    vec_t tbl[$];
    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic obs_t observe(input bit big);
        obs_t o;
        if (big) o = {b_credit, b_dispReq, b_changeReq, b_coinReject, b_busy};
        else     o = {credit, dispReq, changeReq, coinReject, busy};
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got credit=%0d dispReq=%b changeReq=%b coinReject=%b busy=%b, expected credit=%0d dispReq=%b changeReq=%b coinReject=%b busy=%b",
                     name, act.credit, act.dispReq, act.changeReq, act.coinReject, act.busy,
                     exp.credit, exp.dispReq, exp.changeReq, exp.coinReject, exp.busy);
        end
    endtask

    task automatic add(input logic ins, input logic [1:0] val, input logic can, input logic da,
                       input logic ca, input logic [3:0] cr, input logic dr, input logic chr,
                       input logic rej, input logic bsy);
        vec_t v;
        v.ins = ins; v.val = val; v.can = can; v.da = da; v.ca = ca;
        v.exp = {cr, dr, chr, rej, bsy};
        tbl.push_back(v);
    endtask

    // Inputs are driven 1 time unit after a rising edge; the effect is sampled 1 unit after the next.
    task automatic run_table(input string phase, input bit big);
        obs_t exp;
        for (int i = 0; i < tbl.size(); i++) begin
            coinInserted = tbl[i].ins;
            coinValue    = tbl[i].val;
            cancel       = tbl[i].can;
            dispAck      = tbl[i].da;
            changeAck    = tbl[i].ca;
            sb.push_back(tbl[i].exp);
            @(posedge clock);
            #1;
            exp = sb.pop_front();
            check($sformatf("%s[%0d]", phase, i), observe(big), exp);
        end
        tbl.delete();
        coinInserted = 1'b0; coinValue = 2'b00; cancel = 1'b0; dispAck = 1'b0; changeAck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", observe(0), '0);
        check("reset_state_big", observe(1), '0);
        reset_N = 1'b1;

        //  ins val  can da ca | credit dispReq changeReq reject busy
        // Coins 1+3 reach the price; dispReq two cycles after the second edge.
        add(1, 2'b01, 0, 0, 0,  1, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,  1, 0, 0, 0, 0);
        add(1, 2'b10, 0, 0, 0,  4, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,  4, 1, 0, 0, 1);
        add(0, 2'b00, 0, 0, 0,  4, 1, 0, 0, 1);
        add(0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0);
        add(0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0);
        run_table("vend_1_3", 0);

        // Two 5-unit coins with vends interleaved; a held coin counts once, coin in DISPENSE rejected.
        add(1, 2'b11, 0, 0, 0,  5, 0, 0, 0, 0);
        add(1, 2'b11, 0, 0, 0,  5, 1, 0, 0, 1);
        add(0, 2'b00, 0, 1, 0,  1, 0, 0, 0, 0);
        add(1, 2'b11, 0, 0, 0,  6, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,  6, 1, 0, 0, 1);
        add(1, 2'b01, 0, 0, 0,  6, 1, 0, 1, 1);
        add(0, 2'b00, 0, 0, 0,  6, 1, 0, 0, 1);
        add(0, 2'b00, 0, 1, 0,  2, 0, 0, 0, 0);
        // Credit 8 gives two vends separated by a dispReq-low cycle.
        add(1, 2'b01, 0, 0, 0,  3, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,  3, 0, 0, 0, 0);
        add(1, 2'b11, 0, 0, 0,  8, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,  8, 1, 0, 0, 1);
        add(0, 2'b00, 0, 1, 0,  4, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,  4, 1, 0, 0, 1);
        add(0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0);
        run_table("vend_5_5", 0);

        // Cancel with zero credit ignored; cancel refund of 3; spurious acks; cancel+coin rejected.
        add(0, 2'b00, 1, 0, 0,  0, 0, 0, 0, 0);
        add(1, 2'b10, 0, 0, 0,  3, 0, 0, 0, 0);
        add(0, 2'b00, 1, 0, 0,  3, 0, 1, 0, 1);
        add(0, 2'b00, 0, 0, 1,  2, 0, 1, 0, 1);
        add(0, 2'b00, 0, 1, 0,  2, 0, 1, 0, 1);
        add(0, 2'b00, 0, 0, 1,  1, 0, 1, 0, 1);
        add(0, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0);
        add(1, 2'b01, 0, 0, 0,  1, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,  1, 0, 0, 0, 0);
        add(1, 2'b01, 1, 0, 0,  1, 0, 1, 1, 1);
        add(0, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0);
        run_table("cancel", 0);

        // Credit 2 idles; REFUND appears 8 cycles after the credit update; coin in REFUND rejected.
        add(1, 2'b01, 0, 0, 0,  1, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,  1, 0, 0, 0, 0);
        add(1, 2'b01, 0, 0, 0,  2, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) add(0, 2'b00, 0, 0, 0,  2, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,  2, 0, 1, 0, 1);
        add(1, 2'b11, 0, 0, 0,  2, 0, 1, 1, 1);
        add(0, 2'b00, 0, 0, 1,  1, 0, 1, 0, 1);
        add(0, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0);
        run_table("timeout", 0);

        // Reset asserted between edges while dispensing clears outputs without waiting for a clock.
        add(1, 2'b11, 0, 0, 0,  5, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,  5, 1, 0, 0, 1);
        run_table("pre_reset", 0);
        #3;
        reset_N = 1'b0;
        #1;
        check("async_reset", observe(0), '0);
        check("async_reset_big", observe(1), '0);
        @(posedge clock);
        #1;
        reset_N = 1'b1;
        add(0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 0);
        run_table("post_reset", 0);

        // Price above max credit: build 13, overflow and invalid codes rejected, 15 accepted exactly.
        add(1, 2'b11, 0, 0, 0,  5, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,  5, 0, 0, 0, 0);
        add(1, 2'b11, 0, 0, 0, 10, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0, 10, 0, 0, 0, 0);
        add(1, 2'b10, 0, 0, 0, 13, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0, 13, 0, 0, 0, 0);
        add(1, 2'b10, 0, 0, 0, 13, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 13, 0, 0, 0, 0);
        add(1, 2'b00, 0, 0, 0, 13, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 13, 0, 0, 0, 0);
        add(1, 2'b01, 0, 0, 0, 14, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0, 14, 0, 0, 0, 0);
        add(1, 2'b01, 0, 0, 0, 15, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0, 15, 0, 0, 0, 0);
        add(1, 2'b01, 0, 0, 0, 15, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 15, 0, 0, 0, 0);
        run_table("overflow", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Top-level sequencer for the coin-operated vending datapath.
- Detects coin insertions and accumulates credit.
- Arbitrates the single credit register between three users: vending, cancel-refund and inactivity-timeout refund.
- Drives req/ack handshakes to the product dispenser and the change hopper. Sits between the coin acceptor and the two mechanism drivers.

Parameters:
- PRICE, 4, credit units per item.
- CREDIT_W, 4, credit register width; maximum credit is 2**CREDIT_W-1.
- TIMEOUT, 255, idle cycles with nonzero credit before auto-refund (≥2).

Ports:
- clock  input  1  system clock
- reset_N  input  1  asynchronous active-low reset
- coinInserted  input  1  coin present; a rising edge marks one insertion
- coinValue  input  2  coin code, valid on the rising edge of coinInserted: 01=1 unit, 10=3 units, 11=5 units, 00=invalid
- cancel  input  1  user refund request, level-sampled
- dispAck  input  1  one-cycle pulse: item released
- changeAck  input  1  one-cycle pulse: one unit returned
- dispReq  output  1  dispense request, held until dispAck
- changeReq  output  1  change request, held while refunding
- credit  output  CREDIT_W  current credit (registered)
- coinReject  output  1  one-cycle pulse: coin refused
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clock); reset_N asynchronous, active-low.
- Reset values: state=IDLE, credit=0, dispReq=0, changeReq=0, coinReject=0, busy=0, edge register=0, timeout counter=0.
- Reset mid-handshake aborts immediately; credit is lost.
- Edge detect: coinEdge = coinInserted & ~coinInserted_q. A held coin counts once. Inputs are already synchronous to clock.
- States:
  - IDLE.
  - DISPENSE: dispReq=1.
  - REFUND: changeReq=1 while credit>0.
- All outputs except coinReject are Moore outputs.
- IDLE, priority order:
  1. cancel & credit>0 → REFUND. A coinEdge in the same cycle is rejected.
  2. coinEdge with valid code and credit+units ≤ max → credit += units next cycle.
  3. coinEdge with code 00 or overflow → coinReject=1 next cycle; credit unchanged.
  4. credit ≥ PRICE (registered value) → DISPENSE.
  5. timeout hit → REFUND.
  - Cancel with credit=0 is ignored.
- Latency: a coin edge in cycle N updates credit at N+1. If credit ≥ PRICE, dispReq rises at N+2.
- DISPENSE:
  - On dispAck: credit -= PRICE at the next edge; return to IDLE; dispReq low.
  - IDLE then re-evaluates, so each vend has at least one dispReq-low cycle between requests.
  - A remainder below PRICE stays as credit.
  - cancel is ignored in DISPENSE.
- REFUND:
  - Each cycle with changeAck=1 decrements credit by 1.
  - When credit reaches 0 → IDLE; changeReq is low in the cycle credit reads 0.
  - changeAck while credit=0 is ignored.
- Any coinEdge outside IDLE → coinReject pulse; credit unchanged.
- Timeout counter:
  - Counts in IDLE while credit>0.
  - Clears on coinEdge, on leaving IDLE, or when credit=0.
  - When the count reaches TIMEOUT-1 → REFUND next cycle.
- dispAck outside DISPENSE is ignored. Spurious acks never change credit.
- Width rule: sum computed CREDIT_W+1 bits wide for the overflow check; credit never wraps.

Decomposition:
- Package vend_pkg holds:
  - state enum vend_state_t {IDLE, DISPENSE, REFUND}.
  - Coin code constants COIN_1/COIN_3/COIN_5.
  - Function coin_units(code) returning the unit value, 0 for invalid.
- One sub-module, coin_edge_detect: registers coinInserted and outputs a one-cycle coinEdge plus the coinValue captured on that edge.
- Timeout counter and FSM live in vend_controller.

Test Plan:
- Reset, then coins 01,10 (credit 1→4) → dispReq high 2 cycles after the second edge; dispAck → credit 0, dispReq low next cycle, busy 0.
- Coin 11 then 11 (credit 5, then 10; vend of first 5 interleaved) → one vend per ≥4 units; final credit matches sum−4·vends; dispReq drops between consecutive vends.
- Credit 3, cancel → REFUND, changeReq high; three changeAck pulses → credit 3→2→1→0, changeReq low, IDLE.
- Credit 13 in IDLE with PRICE=16 override, coin 10 → coinReject pulse, credit stays 13; coinValue 00 edge → coinReject.
- Credit 2, no activity, TIMEOUT=8 → REFUND entered 8 cycles after last coin; coin edge during REFUND → coinReject, credit unaffected.
- Assert reset_N low mid-DISPENSE with dispReq=1 → dispReq, credit, busy 0 asynchronously; dispAck after reset release ignored.
